// File: rtl/mem_pkg.sv
// Shared encodings for the memory stage: funct3 access sizes, writeback source select and FSM states.
package mem_pkg;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

  typedef enum logic {ST_IDLE = 1'b0, ST_WAIT = 1'b1} state_t;
endpackage

// File: rtl/mem_access_stage_load_extend.sv
// Load lane select plus sign/zero extension; purely combinational, zero latency, no flow control.
module load_extend
  import mem_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  a_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] data_o
);
  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    lane_b = rdata_i[{a_i, 3'b000} +: 8];
    lane_h = a_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    case (funct3_i)
      F3_B:    data_o = {{24{lane_b[7]}}, lane_b};
      F3_BU:   data_o = {24'h0, lane_b};
      F3_H:    data_o = {{16{lane_h[15]}}, lane_h};
      F3_HU:   data_o = {16'h0, lane_h};
      default: data_o = rdata_i;
    endcase
  end
endmodule

// File: rtl/mem_access_stage.sv
// RV32I memory stage + MEM/WB register; 1 cycle M->W when ready, each wait cycle adds one StallM + bubble.
// Backpressure: StallM holds upstream while dmem_ready=0. MISALIGN_TRAP_EN enables misaligned-access trapping.
module mem_access_stage
  import mem_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  input  logic [4:0]  RdM,
  input  logic [31:0] PCPlus4M,
  input  logic [2:0]  Funct3M,
  input  logic        RegWriteM,
  input  logic        MemWriteM,
  input  logic [1:0]  ResultSrcM,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_wstrb,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ready,
  output logic        StallM,
  output logic [31:0] ReadDataW,
  output logic [31:0] ALUResultW,
  output logic [31:0] PCPlus4W,
  output logic [4:0]  RdW,
  output logic        RegWriteW,
  output logic [1:0]  ResultSrcW,
  output logic        MisalignW
);
  state_t      state_q, state_d;
  logic [1:0]  a;
  logic        mem_op, misalign, issue, is_load;
  logic [3:0]  st_strb;
  logic [31:0] st_wdata;

  logic [31:0] addr_q, wdata_q;
  logic [3:0]  wstrb_q;
  logic        we_q;
  logic [1:0]  a_q, ld_a;
  logic [2:0]  f3_q, ld_f3;
  logic [31:0] ld_data;

  logic [31:0] rdata_w_q, alu_w_q, pc4_w_q;
  logic [4:0]  rd_w_q;
  logic        regw_w_q, mis_w_q;
  logic [1:0]  rsrc_w_q;

  assign a       = ALUResultM[1:0];
  assign is_load = (ResultSrcM == RES_MEM);
  assign mem_op  = MemWriteM | is_load;

`ifdef MISALIGN_TRAP_EN
  assign misalign = mem_op & (((Funct3M[1:0] == 2'b01) & a[0]) |
                              ((Funct3M == F3_W) & (a != 2'b00)));
`else
  assign misalign = 1'b0;
`endif

  assign issue = mem_op & ~misalign;

  always_comb begin
    st_strb  = 4'b1111;
    st_wdata = WriteDataM;
    case (Funct3M)
      F3_B: begin
        st_strb  = 4'b0001 << a;
        st_wdata = {4{WriteDataM[7:0]}};
      end
      F3_H: begin
        st_strb  = 4'b0011 << {a[1], 1'b0};
        st_wdata = {2{WriteDataM[15:0]}};
      end
      default: ;
    endcase
    if (!MemWriteM) st_strb = 4'b0000;
  end

  // Captured on every IDLE issue so WAIT never depends on what upstream does.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      we_q    <= 1'b0;
      a_q     <= '0;
      f3_q    <= '0;
    end else if (state_q == ST_IDLE && issue) begin
      addr_q  <= {ALUResultM[31:2], 2'b00};
      wdata_q <= st_wdata;
      wstrb_q <= st_strb;
      we_q    <= MemWriteM;
      a_q     <= a;
      f3_q    <= Funct3M;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_WAIT: if (dmem_ready) state_d = ST_IDLE;
      default: if (issue && !dmem_ready) state_d = ST_WAIT;
    endcase
  end

  always_comb begin
    dmem_req   = issue;
    dmem_we    = issue & MemWriteM;
    dmem_addr  = {ALUResultM[31:2], 2'b00};
    dmem_wdata = st_wdata;
    dmem_wstrb = issue ? st_strb : 4'b0000;
    StallM     = issue & ~dmem_ready;
    ld_a       = a;
    ld_f3      = Funct3M;
    if (state_q == ST_WAIT) begin
      dmem_req   = 1'b1;
      dmem_we    = we_q;
      dmem_addr  = addr_q;
      dmem_wdata = wdata_q;
      dmem_wstrb = wstrb_q;
      StallM     = ~dmem_ready;
      ld_a       = a_q;
      ld_f3      = f3_q;
    end
  end

  load_extend u_load_extend (
    .rdata_i  (dmem_rdata),
    .a_i      (ld_a),
    .funct3_i (ld_f3),
    .data_o   (ld_data)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdata_w_q <= '0;
      alu_w_q   <= '0;
      pc4_w_q   <= '0;
      rd_w_q    <= '0;
      regw_w_q  <= 1'b0;
      rsrc_w_q  <= RES_ALU;
      mis_w_q   <= 1'b0;
    end else if (StallM) begin
      rd_w_q   <= '0;
      regw_w_q <= 1'b0;
      rsrc_w_q <= RES_ALU;
      mis_w_q  <= 1'b0;
    end else begin
      rdata_w_q <= (is_load && !misalign) ? ld_data : 32'h0;
      alu_w_q   <= ALUResultM;
      pc4_w_q   <= PCPlus4M;
      rd_w_q    <= RdM;
      regw_w_q  <= RegWriteM & ~misalign;
      rsrc_w_q  <= ResultSrcM;
      mis_w_q   <= misalign;
    end
  end

  assign ReadDataW  = rdata_w_q;
  assign ALUResultW = alu_w_q;
  assign PCPlus4W   = pc4_w_q;
  assign RdW        = rd_w_q;
  assign RegWriteW  = regw_w_q;
  assign ResultSrcW = rsrc_w_q;
  assign MisalignW  = mis_w_q;
endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: expected W bundles queued at issue, compared at retirement.
module tb_mem_access_stage;
  import mem_pkg::*;

  typedef struct packed {
    logic [31:0] rdata;
    logic [31:0] alu;
    logic [31:0] pc4;
    logic [4:0]  rd;
    logic        regw;
    logic [1:0]  rsrc;
    logic        mis;
  } wb_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] ALUResultM, WriteDataM, PCPlus4M, dmem_rdata;
  logic [4:0]  RdM;
  logic [2:0]  Funct3M;
  logic        RegWriteM, MemWriteM, dmem_ready;
  logic [1:0]  ResultSrcM;
  logic        dmem_req, dmem_we, StallM;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic [31:0] ReadDataW, ALUResultW, PCPlus4W;
  logic [4:0]  RdW;
  logic        RegWriteW, MisalignW;
  logic [1:0]  ResultSrcW;

  int  checks = 0;
  int  passed = 0;
  wb_t sb[$];

  always #5 clk = ~clk;

  mem_access_stage dut (
    .clk(clk), .reset_n(reset_n),
    .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .RdM(RdM), .PCPlus4M(PCPlus4M),
    .Funct3M(Funct3M), .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_wstrb(dmem_wstrb), .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready), .StallM(StallM),
    .ReadDataW(ReadDataW), .ALUResultW(ALUResultW), .PCPlus4W(PCPlus4W), .RdW(RdW),
    .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW), .MisalignW(MisalignW)
  );

  function automatic wb_t obs_w();
    return '{ReadDataW, ALUResultW, PCPlus4W, RdW, RegWriteW, ResultSrcW, MisalignW};
  endfunction

  task automatic set_m(input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] rd,
                       input logic [31:0] pc4, input logic [2:0] f3, input logic regw,
                       input logic memw, input logic [1:0] rsrc);
    ALUResultM = alu; WriteDataM = wd; RdM = rd; PCPlus4M = pc4;
    Funct3M = f3; RegWriteM = regw; MemWriteM = memw; ResultSrcM = rsrc;
  endtask

  task automatic test_reset();
    wb_t e;
    reset_n = 1'b0;
    set_m(0, 0, 0, 0, 3'b000, 0, 0, RES_ALU);
    dmem_ready = 1'b0; dmem_rdata = 32'h0;
    repeat (2) @(negedge clk);
    e = '0;
    checks++; if (obs_w() !== e) $display("FAIL reset_w got=%h want=%h", obs_w(), e); else passed++;
    checks++; if (dmem_req !== 1'b0) $display("FAIL reset_req got=%b want=0", dmem_req); else passed++;
    checks++; if (StallM !== 1'b0) $display("FAIL reset_stall got=%b want=0", StallM); else passed++;
    reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_stores();
    wb_t e;
    logic [31:0] addrs [3] = '{32'h100, 32'h103, 32'h102};
    logic [31:0] wds   [3] = '{32'hDEADBEEF, 32'h000000A5, 32'h00001234};
    logic [2:0]  f3s   [3] = '{F3_W, F3_B, F3_H};
    logic [3:0]  strbs [3] = '{4'b1111, 4'b1000, 4'b1100};
    logic [31:0] wexp  [3] = '{32'hDEADBEEF, 32'hA5A5A5A5, 32'h12341234};
    dmem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_m(addrs[i], wds[i], 5'd0, 32'h1000 + 4*i, f3s[i], 1'b0, 1'b1, RES_ALU);
      sb.push_back('{32'h0, addrs[i], 32'h1000 + 4*i, 5'd0, 1'b0, RES_ALU, 1'b0});
      @(negedge clk);
      checks++;
      if (dmem_req !== 1'b1 || dmem_we !== 1'b1 || dmem_addr !== {addrs[i][31:2], 2'b00} || StallM !== 1'b0)
        $display("FAIL st_bus[%0d] req=%b we=%b addr=%h stall=%b want addr=%h", i, dmem_req, dmem_we, dmem_addr, StallM, {addrs[i][31:2], 2'b00});
      else passed++;
      checks++; if (dmem_wstrb !== strbs[i]) $display("FAIL st_wstrb[%0d] got=%b want=%b", i, dmem_wstrb, strbs[i]); else passed++;
      checks++; if (dmem_wdata !== wexp[i]) $display("FAIL st_wdata[%0d] got=%h want=%h", i, dmem_wdata, wexp[i]); else passed++;
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++; if (obs_w() !== e) $display("FAIL st_w[%0d] got=%h want=%h", i, obs_w(), e); else passed++;
    end
  endtask

  task automatic test_back_to_back();
    wb_t e;
    logic [2:0]  f3s  [6] = '{F3_B, F3_BU, F3_H, F3_HU, F3_W, F3_B};
    logic [31:0] adr  [6] = '{32'h102, 32'h102, 32'h102, 32'h100, 32'h104, 32'h100};
    logic [31:0] rdv  [6] = '{32'h00800000, 32'h00800000, 32'h80010000, 32'h0000F00F, 32'h12345678, 32'h0000007F};
    logic [31:0] xp   [6] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF8001, 32'h0000F00F, 32'h12345678, 32'h0000007F};
    dmem_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      set_m(adr[i], 32'h0, 5'(i + 1), 32'h2000 + 4*i, f3s[i], 1'b1, 1'b0, RES_MEM);
      dmem_rdata = rdv[i];
      sb.push_back('{xp[i], adr[i], 32'h2000 + 4*i, 5'(i + 1), 1'b1, RES_MEM, 1'b0});
      @(negedge clk);
      checks++;
      if (dmem_req !== 1'b1 || dmem_we !== 1'b0 || dmem_wstrb !== 4'b0000 || StallM !== 1'b0)
        $display("FAIL ld_bus[%0d] req=%b we=%b wstrb=%b stall=%b want 1/0/0000/0", i, dmem_req, dmem_we, dmem_wstrb, StallM);
      else passed++;
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++; if (obs_w() !== e) $display("FAIL ld_w[%0d] got=%h want=%h", i, obs_w(), e); else passed++;
    end
  endtask

  task automatic test_nonmem();
    wb_t e;
    set_m(32'h55AA0000, 32'h0, 5'd3, 32'h3004, F3_W, 1'b1, 1'b0, RES_ALU);
    dmem_ready = 1'b1; dmem_rdata = 32'hFFFFFFFF;
    sb.push_back('{32'h0, 32'h55AA0000, 32'h3004, 5'd3, 1'b1, RES_ALU, 1'b0});
    @(negedge clk);
    checks++; if (dmem_req !== 1'b0 || StallM !== 1'b0) $display("FAIL alu_bus req=%b stall=%b want 0/0", dmem_req, StallM); else passed++;
    @(posedge clk); #1;
    e = sb.pop_front();
    checks++; if (obs_w() !== e) $display("FAIL alu_w got=%h want=%h", obs_w(), e); else passed++;
    set_m(32'h00000010, 32'h0, 5'd1, 32'h3008, F3_B, 1'b1, 1'b0, RES_PC4);
    dmem_ready = 1'b0;
    sb.push_back('{32'h0, 32'h00000010, 32'h3008, 5'd1, 1'b1, RES_PC4, 1'b0});
    @(negedge clk);
    checks++; if (dmem_req !== 1'b0 || StallM !== 1'b0) $display("FAIL pc4_bus req=%b stall=%b want 0/0", dmem_req, StallM); else passed++;
    @(posedge clk); #1;
    e = sb.pop_front();
    checks++; if (obs_w() !== e) $display("FAIL pc4_w got=%h want=%h", obs_w(), e); else passed++;
  endtask

  task automatic test_wait_load();
    wb_t e;
    int stalls = 0;
    set_m(32'h200, 32'h0, 5'd7, 32'h1004, F3_W, 1'b1, 1'b0, RES_MEM);
    dmem_ready = 1'b0; dmem_rdata = 32'hBAD0BAD0;
    sb.push_back('{32'hCAFEF00D, 32'h200, 32'h1004, 5'd7, 1'b1, RES_MEM, 1'b0});
    for (int c = 0; c < 4; c++) begin
      if (c == 1) set_m(32'h37C, 32'hFFFFFFFF, 5'd9, 32'h9999, F3_B, 1'b1, 1'b1, RES_ALU);
      if (c == 3) begin
        set_m(32'h200, 32'h0, 5'd7, 32'h1004, F3_W, 1'b1, 1'b0, RES_MEM);
        dmem_ready = 1'b1; dmem_rdata = 32'hCAFEF00D;
      end
      @(negedge clk);
      checks++;
      if (dmem_req !== 1'b1 || dmem_addr !== 32'h200 || dmem_we !== 1'b0 || dmem_wstrb !== 4'b0000)
        $display("FAIL wait_bus[%0d] req=%b addr=%h we=%b wstrb=%b want 1/00000200/0/0000", c, dmem_req, dmem_addr, dmem_we, dmem_wstrb);
      else passed++;
      if (StallM === 1'b1) stalls++;
      @(posedge clk); #1;
      if (c < 3) begin
        checks++;
        if (RegWriteW !== 1'b0 || RdW !== 5'd0 || ResultSrcW !== RES_ALU)
          $display("FAIL wait_bubble[%0d] regw=%b rd=%0d rsrc=%b want 0/0/00", c, RegWriteW, RdW, ResultSrcW);
        else passed++;
      end
    end
    checks++; if (stalls != 3) $display("FAIL wait_stalls got=%0d want=3", stalls); else passed++;
    e = sb.pop_front();
    checks++; if (obs_w() !== e) $display("FAIL wait_w got=%h want=%h", obs_w(), e); else passed++;
  endtask

  task automatic test_reset_in_wait();
    set_m(32'h40, 32'h0, 5'd4, 32'h5004, F3_W, 1'b1, 1'b0, RES_MEM);
    dmem_ready = 1'b0;
    @(posedge clk); #1;
    #2;
    reset_n = 1'b0;
    set_m(0, 0, 0, 0, 3'b000, 0, 0, RES_ALU);
    #1;
    checks++; if (dmem_req !== 1'b0 || StallM !== 1'b0) $display("FAIL rstwait_bus req=%b stall=%b want 0/0", dmem_req, StallM); else passed++;
    checks++; if (obs_w() !== wb_t'(0)) $display("FAIL rstwait_w got=%h want=0", obs_w()); else passed++;
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    dmem_ready = 1'b0;
    @(negedge clk);
    checks++; if (dmem_req !== 1'b0 || StallM !== 1'b0) $display("FAIL rstwait_idle req=%b stall=%b want 0/0", dmem_req, StallM); else passed++;
    @(posedge clk); #1;
  endtask

  task automatic test_misalign();
    wb_t e;
    set_m(32'h101, 32'h0, 5'd12, 32'h6004, F3_W, 1'b1, 1'b0, RES_MEM);
    dmem_ready = 1'b1; dmem_rdata = 32'h11223344;
`ifdef MISALIGN_TRAP_EN
    @(negedge clk);
    checks++; if (dmem_req !== 1'b0 || StallM !== 1'b0) $display("FAIL mis_bus req=%b stall=%b want 0/0", dmem_req, StallM); else passed++;
    @(posedge clk); #1;
    checks++;
    if (MisalignW !== 1'b1 || RegWriteW !== 1'b0 || RdW !== 5'd12)
      $display("FAIL mis_w mis=%b regw=%b rd=%0d want 1/0/12", MisalignW, RegWriteW, RdW);
    else passed++;
`else
    sb.push_back('{32'h11223344, 32'h101, 32'h6004, 5'd12, 1'b1, RES_MEM, 1'b0});
    @(negedge clk);
    checks++;
    if (dmem_req !== 1'b1 || dmem_addr !== 32'h100 || StallM !== 1'b0)
      $display("FAIL mis_bus req=%b addr=%h stall=%b want 1/00000100/0", dmem_req, dmem_addr, StallM);
    else passed++;
    @(posedge clk); #1;
    e = sb.pop_front();
    checks++; if (obs_w() !== e) $display("FAIL mis_w got=%h want=%h", obs_w(), e); else passed++;
`endif
  endtask

  initial begin
    test_reset();
    test_stores();
    test_back_to_back();
    test_nonmem();
    test_wait_load();
    test_reset_in_wait();
    test_misalign();
    checks++;
    if (sb.size() != 0) $display("FAIL sb_drain left=%0d want=0", sb.size()); else passed++;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
